// File: rtl/linear_arb.sv
// Round-robin arbiter sharing one linear engine among NUM_REQ requesters,
// with a per-job engine clear, a RUN watchdog and per-requester done/error pulses.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no job; round-robin pick among pending requests
// CLR    | grant held, one-cycle local clear to the engine
// RUN    | engine started; wait for eng_done or watchdog expiry
// RESP   | one-cycle req_done (completed) or req_err (aborted) to the owner
module linear_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               eng_clr,
  output logic               eng_start,
  input  logic               eng_done,
  output logic [NUM_REQ-1:0] req_done,
  output logic [NUM_REQ-1:0] req_err,
  output logic               busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [CNT_W-1:0]   wd_cnt;
  logic               job_ok;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] sel_oh;

  // Scan starts one past the last served requester, so the previous owner
  // is considered last and only wins when nobody else is pending.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_vld && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign sel_oh = NUM_REQ'(1) << sel;

  // A done arriving on the last allowed cycle wins over the watchdog.
  assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT - 1)) && !eng_done;

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    eng_clr   = 1'b0;
    eng_start = 1'b0;
    req_done  = '0;
    req_err   = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (win_vld) state_nxt = S_CLR;
      end
      S_CLR: begin
        gnt       = sel_oh;
        eng_clr   = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        gnt       = sel_oh;
        eng_start = 1'b1;
        if (eng_done || timeout_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        gnt       = sel_oh;
        if (job_ok) req_done = sel_oh;
        else        req_err  = sel_oh;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= IDX_W'(NUM_REQ - 1);
      sel    <= '0;
      wd_cnt <= '0;
      job_ok <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && win_vld) sel <= win_idx;
      if (state == S_CLR) begin
        wd_cnt <= '0;
      end else if (state == S_RUN && state_nxt == S_RUN) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      // Only the exit cycle of RUN matters: eng_done high there means completion.
      if (state == S_RUN) job_ok <= eng_done;
      if (state == S_RESP) rr_ptr <= sel;
    end
  end

endmodule

// File: tb/tb_linear_arb.sv
// Self-checking bench for linear_arb: directed scenarios plus randomized jobs
// checked against a job-level round-robin / watchdog reference model.
module tb_linear_arb;

  localparam int N  = 4;
  localparam int TO = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   sel;
  logic         eng_clr;
  logic         eng_start;
  logic         eng_done;
  logic [N-1:0] req_done;
  logic [N-1:0] req_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int last;

  always #5 clk = ~clk;

  linear_arb #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel),
    .eng_clr(eng_clr), .eng_start(eng_start), .eng_done(eng_done),
    .req_done(req_done), .req_err(req_err), .busy(busy)
  );

  // Reference arbitration rule: first pending requester after the last one served.
  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int i = 1; i <= N; i++) if (r[(from + i) % N]) return (from + i) % N;
    return -1;
  endfunction

  // One complete job; done_at is the RUN cycle (1-based) with eng_done, 0 or >TO means never.
  task automatic run_job(input logic [N-1:0] reqv, input int done_at, input bit drop,
                         input string tag);
    int w, len;
    bit ok;
    logic [N-1:0] oh;
    logic [14:0] exp_v;
    w   = pick(reqv, last);
    ok  = (done_at >= 1 && done_at <= TO);
    len = ok ? done_at : TO;
    oh  = N'(1) << w;
    req = reqv;
    eng_done = 1'b0;
    @(negedge clk);
    exp_v = {oh, 1'b1, 1'b0, 1'b1, 4'b0, 4'b0};
    checks++;
    if ({gnt, eng_clr, eng_start, busy, req_done, req_err} !== exp_v) begin
      errors++;
      $display("FAIL %s clr_phase: got %b need %b", tag,
               {gnt, eng_clr, eng_start, busy, req_done, req_err}, exp_v);
    end
    checks++;
    if (sel !== 2'(w)) begin
      errors++;
      $display("FAIL %s sel: got %0d need %0d", tag, sel, w);
    end
    @(negedge clk);
    for (int k = 1; k <= len; k++) begin
      exp_v = {oh, 1'b0, 1'b1, 1'b1, 4'b0, 4'b0};
      checks++;
      if ({gnt, eng_clr, eng_start, busy, req_done, req_err} !== exp_v) begin
        errors++;
        $display("FAIL %s run_cycle_%0d: got %b need %b", tag, k,
                 {gnt, eng_clr, eng_start, busy, req_done, req_err}, exp_v);
      end
      if (drop && k == 1) req[w] = 1'b0;
      eng_done = (k == done_at);
      @(negedge clk);
    end
    eng_done = 1'b0;
    exp_v = {oh, 1'b0, 1'b0, 1'b1, (ok ? oh : 4'b0), (ok ? 4'b0 : oh)};
    checks++;
    if ({gnt, eng_clr, eng_start, busy, req_done, req_err} !== exp_v) begin
      errors++;
      $display("FAIL %s resp_phase: got %b need %b", tag,
               {gnt, eng_clr, eng_start, busy, req_done, req_err}, exp_v);
    end
    @(negedge clk);
    checks++;
    if ({gnt, eng_clr, eng_start, busy, req_done, req_err, sel} !== {15'b0, 2'(w)}) begin
      errors++;
      $display("FAIL %s idle_after: got %b need %b", tag,
               {gnt, eng_clr, eng_start, busy, req_done, req_err, sel}, {15'b0, 2'(w)});
    end
    last = w;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '1;
    eng_done = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, eng_clr, eng_start, busy, req_done, req_err, sel} !== 17'b0) begin
      errors++;
      $display("FAIL reset_state: got %b need all zero",
               {gnt, eng_clr, eng_start, busy, req_done, req_err, sel});
    end
    rst_n = 1'b1;
    req = '0;
    eng_done = 1'b0;
    last = N - 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    run_job(4'b0100, 10, 1'b0, "single");
    req = '0;
    @(negedge clk);
    checks++;
    if ({busy, gnt} !== 5'b0) begin
      errors++;
      $display("FAIL single_busy_low: got busy=%b gnt=%b need 0", busy, gnt);
    end
  endtask

  task automatic test_timeout();
    run_job(4'b0010, 0, 1'b0, "timeout");
    // rr pointer must now sit on 1, so 2 beats 1 here
    run_job(4'b0110, 2, 1'b0, "timeout_rr_advance");
  endtask

  task automatic test_boundary();
    run_job(4'b1000, TO, 1'b0, "boundary_last_cycle");
    run_job(4'b0001, TO - 1, 1'b0, "boundary_prev_cycle");
  endtask

  task automatic test_reset_mid_run();
    req = 4'b1111;
    eng_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, eng_clr, eng_start, busy, req_done, req_err, sel} !== 17'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got %b need all zero",
               {gnt, eng_clr, eng_start, busy, req_done, req_err, sel});
    end
    rst_n = 1'b1;
    last = N - 1;
    run_job(4'b1111, 3, 1'b0, "after_reset_first");
  endtask

  task automatic test_fairness();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last = N - 1;
    for (int j = 0; j < 5; j++) run_job(4'b1111, 3, 1'b0, "fairness");
  endtask

  task automatic test_noise();
    req = '0;
    eng_done = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, gnt, req_done, req_err} !== 13'b0) begin
      errors++;
      $display("FAIL noise_idle_done: got %b need 0", {busy, gnt, req_done, req_err});
    end
    eng_done = 1'b0;
    run_job(4'b0100, 4, 1'b1, "noise_drop_req");
  endtask

  task automatic test_random();
    for (int j = 0; j < 30; j++) begin
      run_job(4'($urandom_range(1, 15)), int'($urandom_range(0, TO + 2)),
              1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    req = '0;
    eng_done = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_timeout();
    test_boundary();
    test_reset_mid_run();
    test_fairness();
    test_noise();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
